instr_prefetch_mem: RTL and testbench

Parametrised instruction memory with an integrated fetch engine and prefetch FIFO for the MIPS CPU. It replaces the bare address-in/data-out instruction memory: it holds the program in a synchronous-read word array and autonomously fetches sequential words from a fetch PC. It delivers them to the decode stage over a valid/ready handshake and supports branch/jump redirect with flush and a write port for program loading.

---
 rtl/instr_prefetch_mem.sv | 137 +++++++++++++
 tb/tb_instr_prefetch_mem.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_mem
// Description : Instruction memory with an integrated sequential fetch
//               engine and prefetch FIFO. Words are read from a synchronous
//               RAM at fetchPc, buffered in a small FIFO and handed to the
//               decode stage over a valid/ready handshake. A redirect flushes
//               everything buffered or in flight and restarts fetch at a new
//               word address. A write port allows program loading.
// Ports       : clk          - single clock, rising edge
//               rst_n        - synchronous, active-low reset
//               redirect     - flush and restart fetch at redirectAddr
//               redirectAddr - new fetch word address
//               outReady     - consumer accepts the head word this cycle
//               outValid     - outInstr/outAddr hold a valid word
//               outInstr     - instruction word at FIFO head
//               outAddr      - word address of outInstr
//               wrEn         - program-load write enable
//               wrAddr       - program-load word address
//               wrData       - program-load data
//               fillLevel    - current FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [ADDR_WIDTH-1:0]      redirectAddr,
    input  logic                       outReady,
    output logic                       outValid,
    output logic [DATA_WIDTH-1:0]      outInstr,
    output logic [ADDR_WIDTH-1:0]      outAddr,
    input  logic                       wrEn,
    input  logic [ADDR_WIDTH-1:0]      wrAddr,
    input  logic [DATA_WIDTH-1:0]      wrData,
    output logic [$clog2(DEPTH):0]     fillLevel
);

    localparam int                 c_ptr_w     = $clog2(DEPTH);
    localparam int                 c_cnt_w     = c_ptr_w + 1;
    localparam int                 c_mem_words = 1 << ADDR_WIDTH;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);

    // Program storage; never reset so a reset keeps the loaded program.
    logic [DATA_WIDTH-1:0] r_mem [0:c_mem_words-1];

    // Fetch stage
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    // Prefetch FIFO
    logic [DATA_WIDTH-1:0] r_fifo_data [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_fifo_addr [0:DEPTH-1];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic [c_cnt_w-1:0]    w_occupancy;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;

    // The in-flight word already owns a FIFO slot, so counting it here makes
    // the push one cycle later always find room.
    assign w_occupancy = r_count + c_cnt_w'(r_rd_valid);
    assign w_issue     = !redirect && (w_occupancy < c_depth);
    assign w_push      = r_rd_valid;
    assign w_pop       = outValid && outReady;

    assign outValid  = (r_count != '0);
    assign fillLevel = r_count;
    // Gate the head with valid so the outputs read zero whenever empty.
    assign outInstr  = outValid ? r_fifo_data[r_rd_ptr] : '0;
    assign outAddr   = outValid ? r_fifo_addr[r_rd_ptr] : '0;

    // Write port
    always_ff @(posedge clk) begin
        if (wrEn) begin
            r_mem[wrAddr] <= wrData;
        end
    end

    // Read port and FIFO storage. Nonblocking semantics make a same-edge
    // write/read to one address return the old word (read-first).
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rd_data <= r_mem[r_fetch_pc];
            r_rd_addr <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= r_rd_data;
            r_fifo_addr[r_wr_ptr] <= r_rd_addr;
        end
    end

    // Control state: reset beats redirect beats push/pop/issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= ADDR_WIDTH'(RESET_PC);
            r_rd_valid <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirectAddr;
            r_rd_valid <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch_mem
// Description : Self-checking bench for instr_prefetch_mem. Expected words
//               are queued from a bench-side copy of the program whenever a
//               fetch stream is started, and popped on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_mem;

    localparam int c_dw    = 32;
    localparam int c_aw    = 10;
    localparam int c_depth = 4;
    localparam int c_words = 1 << c_aw;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             redirect;
    logic [c_aw-1:0]  redirectAddr;
    logic             outReady;
    logic             outValid;
    logic [c_dw-1:0]  outInstr;
    logic [c_aw-1:0]  outAddr;
    logic             wrEn;
    logic [c_aw-1:0]  wrAddr;
    logic [c_dw-1:0]  wrData;
    logic [2:0]       fillLevel;

    instr_prefetch_mem #(
        .DATA_WIDTH (c_dw),
        .ADDR_WIDTH (c_aw),
        .DEPTH      (c_depth),
        .RESET_PC   (0)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirectAddr (redirectAddr),
        .outReady     (outReady),
        .outValid     (outValid),
        .outInstr     (outInstr),
        .outAddr      (outAddr),
        .wrEn         (wrEn),
        .wrAddr       (wrAddr),
        .wrData       (wrData),
        .fillLevel    (fillLevel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_aw-1:0] addr;
        logic [c_dw-1:0] data;
    } exp_t;

    exp_t            sb_q[$];
    exp_t            mon_e;
    logic [c_dw-1:0] model_mem [0:c_words-1];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              n_words  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Restart the expected stream at start, using the program as it is now.
    task automatic expect_stream(input logic [c_aw-1:0] start, input int n);
        exp_t e;
        logic [c_aw-1:0] a;
        sb_q.delete();
        a = start;
        for (int i = 0; i < n; i++) begin
            e.addr = a;
            e.data = model_mem[a];
            sb_q.push_back(e);
            a = a + 10'd1;
        end
    endtask

    // Redirect with the two-cycle bubble checked, leaving the new head visible.
    task automatic do_redirect(input logic [c_aw-1:0] addr);
        redirect     = 1'b1;
        redirectAddr = addr;
        expect_stream(addr, 64);
        tick;
        redirect = 1'b0;
        check_eq("rdr_gap1", outValid, 0);
        tick;
        check_eq("rdr_gap2", outValid, 0);
        tick;
        check_eq("rdr_valid", outValid, 1);
        check_eq("rdr_addr", outAddr, addr);
    endtask

    // Scoreboard: every handshake that the DUT will honour at the next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && redirect === 1'b0 && outValid === 1'b1 && outReady === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("out_addr", outAddr, mon_e.addr);
                check_eq("out_instr", outInstr, mon_e.data);
                n_words++;
            end
        end
    end

    initial begin
        logic [c_dw-1:0] snap;
        logic [2:0]      max_fill;
        int              valid_cnt;
        int              words_before;
        bit              found;

        rst_n        = 1'b0;
        redirect     = 1'b0;
        redirectAddr = '0;
        outReady     = 1'b0;
        wrEn         = 1'b0;
        wrAddr       = '0;
        wrData       = '0;

        // Program load while held in reset.
        for (int k = 0; k < c_words; k++) begin
            model_mem[k] = 32'h1000_0000 + k;
            wrEn   = 1'b1;
            wrAddr = k[c_aw-1:0];
            wrData = 32'h1000_0000 + k;
            tick;
        end
        wrEn = 1'b0;
        tick; tick; tick;

        check_eq("rst_valid", outValid, 0);
        check_eq("rst_fill", fillLevel, 0);
        check_eq("rst_instr", outInstr, 0);
        check_eq("rst_addr", outAddr, 0);

        // Startup
        expect_stream(10'd0, 64);
        rst_n    = 1'b1;
        outReady = 1'b1;
        tick;
        check_eq("e1_valid", outValid, 0);
        tick;
        check_eq("e2_valid", outValid, 1);
        check_eq("e2_addr", outAddr, 0);
        valid_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (outValid) valid_cnt++;
        end
        check_eq("stream_rate", valid_cnt, 5);
        check_eq("head_addr5", outAddr, 5);

        // Redirect while address 5 is at the head
        do_redirect(10'h200);
        for (int i = 0; i < 4; i++) tick;

        // Wrap-around
        do_redirect(10'h3FE);
        for (int i = 0; i < 4; i++) tick;

        // Backpressure
        outReady = 1'b0;
        snap     = outInstr;
        max_fill = '0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (fillLevel > max_fill) max_fill = fillLevel;
        end
        check_eq("bp_fill", fillLevel, 4);
        check_eq("bp_max", max_fill, 4);
        check_eq("bp_hold", outInstr, snap);
        check_eq("bp_valid", outValid, 1);
        outReady     = 1'b1;
        words_before = n_words;
        for (int i = 0; i < 12; i++) tick;
        check_eq("bp_drain", n_words - words_before, 12);

        // Write collision on the edge that issues the read of 0x40
        redirect     = 1'b1;
        redirectAddr = 10'h040;
        expect_stream(10'h040, 64);
        tick;
        redirect = 1'b0;
        wrEn     = 1'b1;
        wrAddr   = 10'h040;
        wrData   = 32'hDEAD_BEEF;
        tick;
        wrEn = 1'b0;
        model_mem[10'h040] = 32'hDEAD_BEEF;
        tick;
        check_eq("col_addr", outAddr, 10'h040);
        check_eq("col_old", outInstr, 32'h1000_0040);
        for (int i = 0; i < 3; i++) tick;
        do_redirect(10'h040);
        check_eq("col_new", outInstr, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) tick;

        // Reset mid-stream with three words buffered
        outReady = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (fillLevel == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("fill3_found", found, 1);
        rst_n = 1'b0;
        expect_stream(10'd0, 64);
        tick;
        rst_n    = 1'b1;
        outReady = 1'b1;
        check_eq("mrst_fill", fillLevel, 0);
        check_eq("mrst_valid", outValid, 0);
        tick;
        tick;
        check_eq("mrst_restart", outValid, 1);
        check_eq("mrst_addr", outAddr, 0);
        check_eq("mrst_instr", outInstr, 32'h1000_0000);
        for (int i = 0; i < 4; i++) tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
